// File: rtl/instr_mem_loader_if.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_if
// Bundles the byte stream coming from the debug UART receiver and the
// instruction-memory write port / CPU control outputs of instr_mem_loader.
//
//   i_rx_data     [7:0]        received byte
//   i_rx_valid                 one-cycle strobe, i_rx_data valid this cycle
//   o_wr_en                    instruction memory write enable (1-cycle pulse)
//   o_wr_addr     [NBITS-1:0]  byte address of the write
//   o_wr_data     [NBITS-1:0]  instruction word being written
//   o_cpu_enable               1 = CPU/PC may advance
//   o_busy                     1 while a program load is in progress
//   o_error                    sticky overflow flag
//   o_word_count  [7:0]        words written since the last load command
//
// master: the side that feeds bytes and consumes the write port (UART/bench).
// slave : the loader itself.
// -----------------------------------------------------------------------------
interface instr_mem_loader_if #(
   parameter int unsigned NBITS = 32
);
   logic [7:0]       i_rx_data;
   logic             i_rx_valid;
   logic             o_wr_en;
   logic [NBITS-1:0] o_wr_addr;
   logic [NBITS-1:0] o_wr_data;
   logic             o_cpu_enable;
   logic             o_busy;
   logic             o_error;
   logic [7:0]       o_word_count;

   modport master (
      output i_rx_data, i_rx_valid,
      input  o_wr_en, o_wr_addr, o_wr_data, o_cpu_enable, o_busy, o_error,
             o_word_count
   );

   modport slave (
      input  i_rx_data, i_rx_valid,
      output o_wr_en, o_wr_addr, o_wr_data, o_cpu_enable, o_busy, o_error,
             o_word_count
   );
endinterface

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Loads a program into instruction memory from a byte stream and keeps the CPU
// stalled until loading is finished. After CMD_LOAD, every group of four bytes
// (MSB first) becomes one instruction written at byte address 0, 4, 8, ...
// Loading ends on HALT_WORD (which is still written) and releases the CPU;
// CMD_RUN in idle releases the CPU without loading. A word that would not fit
// in CELDAS byte cells is not written and locks the block in ERROR.
//
// Ports:
//   i_clk    clock, rising edge
//   i_reset  synchronous, active-high reset
//   bus      instr_mem_loader_if.slave (byte input, write port, status)
// -----------------------------------------------------------------------------
module instr_mem_loader #(
   parameter int unsigned      NBITS     = 32,
   parameter int unsigned      CELDAS    = 60,
   parameter logic [7:0]       CMD_LOAD  = 8'h4C,
   parameter logic [7:0]       CMD_RUN   = 8'h52,
   parameter logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}}
) (
   input  logic               i_clk,
   input  logic               i_reset,
   instr_mem_loader_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_e;

   // addr + 3 <= CELDAS - 1 rewritten as addr <= CELDAS - 4: no carry out of
   // the addition can ever disturb the bound check.
   localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - 4);

   state_e           state_q, state_d;
   logic [NBITS-1:0] addr_q, addr_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic [NBITS-1:0] word_q, word_d;
   logic             wr_en_q, wr_en_d;
   logic [NBITS-1:0] wr_addr_q, wr_addr_d;
   logic [NBITS-1:0] wr_data_q, wr_data_d;
   logic [7:0]       word_count_q, word_count_d;

   logic [NBITS-1:0] word_shifted;

   // New byte enters at the bottom, so the first byte ends up as the MSB.
   assign word_shifted = {word_q[NBITS-9:0], bus.i_rx_data};

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      // NOTE: the reset is synchronous, so it is the first branch inside the
      // clocked block and i_reset stays out of the sensitivity list.
      if (i_reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         byte_idx_q   <= '0;
         word_q       <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         word_count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state_q      <= state_d;
         addr_q       <= addr_d;
         byte_idx_q   <= byte_idx_d;
         word_q       <= word_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         word_count_q <= word_count_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and datapath logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first, so no path can leave one
      // unassigned and infer a latch.
      state_d      = state_q;
      addr_d       = addr_q;
      byte_idx_d   = byte_idx_q;
      word_d       = word_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      word_count_d = word_count_q;

      case (state_q)
         S_IDLE: begin
            if (bus.i_rx_valid) begin
               if (bus.i_rx_data == CMD_LOAD) begin
                  state_d      = S_RECV;
                  addr_d       = '0;
                  byte_idx_d   = '0;
                  word_count_d = '0;
               end else if (bus.i_rx_data == CMD_RUN) begin
                  state_d = S_DONE;
               end
            end
         end

         S_RECV: begin
            // Command byte values are plain data here.
            if (bus.i_rx_valid) begin
               word_d     = word_shifted;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end

         S_WRITE: begin
            byte_idx_d = '0;
            if (addr_q <= LAST_ADDR) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = word_q;
               if (word_count_q != 8'hFF) begin
                  word_count_d = word_count_q + 8'd1;
               end
               if (word_q == HALT_WORD) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RECV;
                  addr_d  = addr_q + NBITS'(4);
                  // A byte landing in this cycle is byte 0 of the next word.
                  if (bus.i_rx_valid) begin
                     word_d     = word_shifted;
                     byte_idx_d = 2'd1;
                  end
               end
            end else begin
               state_d = S_ERROR;
            end
         end

         default: begin
            // S_DONE / S_ERROR: terminal until reset, bytes ignored.
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.o_wr_en      = wr_en_q;
      bus.o_wr_addr    = wr_addr_q;
      bus.o_wr_data    = wr_data_q;
      bus.o_word_count = word_count_q;
      bus.o_busy       = (state_q == S_RECV) || (state_q == S_WRITE);
      bus.o_cpu_enable = (state_q == S_DONE);
      bus.o_error      = (state_q == S_ERROR);
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
// Self-checking bench for instr_mem_loader. A byte-level reference model keeps
// the expected writes in queues; a negedge monitor compares every write pulse
// against them, and each scenario ends with a status comparison.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

   localparam int unsigned NBITS  = 32;
   localparam int unsigned CELDAS = 60;

   logic clk;
   logic rst;

   instr_mem_loader_if #(.NBITS(NBITS)) bus ();

   instr_mem_loader #(
      .NBITS    (NBITS),
      .CELDAS   (CELDAS),
      .CMD_LOAD (8'h4C),
      .CMD_RUN  (8'h52),
      .HALT_WORD(32'hFFFF_FFFF)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: works on the byte sequence alone.
   // ---------------------------------------------------------------------------
   typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mode_e;

   mode_e       m_mode;
   logic [7:0]  m_bytes[$];
   int unsigned m_addr;
   int unsigned m_count;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_bytes.delete();
      m_addr  = 0;
      m_count = 0;
      exp_addr.delete();
      exp_data.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [31:0] w;
      case (m_mode)
         M_IDLE: begin
            if (b == 8'h4C) begin
               m_mode  = M_LOAD;
               m_bytes.delete();
               m_addr  = 0;
               m_count = 0;
            end else if (b == 8'h52) begin
               m_mode = M_DONE;
            end
         end
         M_LOAD: begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
               w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
               m_bytes.delete();
               if (m_addr + 3 <= CELDAS - 1) begin
                  exp_addr.push_back(m_addr);
                  exp_data.push_back(w);
                  if (m_count < 255) m_count++;
                  if (w == 32'hFFFF_FFFF) m_mode = M_DONE;
                  else m_addr += 4;
               end else begin
                  m_mode = M_ERR;
               end
            end
         end
         default: ;
      endcase
   endtask

   // ---------------------------------------------------------------------------
   // Write monitor
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (!rst && bus.o_wr_en) begin
         check("write_expected", 32'(exp_addr.size() != 0), 32'd1);
         if (exp_addr.size() != 0) begin
            check("wr_addr", bus.o_wr_addr, exp_addr.pop_front());
            check("wr_data", bus.o_wr_data, exp_data.pop_front());
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (all called at posedge + 1)
   // ---------------------------------------------------------------------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_byte(input logic [7:0] b);
      bus.i_rx_data  = b;
      bus.i_rx_valid = 1'b1;
      model_byte(b);
      @(posedge clk);
      #1;
      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = 8'($urandom);
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int i = 3; i >= 0; i--) begin
         drive_byte(w[i*8 +: 8]);
         idle($urandom_range(0, max_gap));
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_wr_en"},      32'(bus.o_wr_en),      32'd0);
      check({tag, "_wr_addr"},    bus.o_wr_addr,         32'd0);
      check({tag, "_wr_data"},    bus.o_wr_data,         32'd0);
      check({tag, "_cpu_enable"}, 32'(bus.o_cpu_enable), 32'd0);
      check({tag, "_busy"},       32'(bus.o_busy),       32'd0);
      check({tag, "_error"},      32'(bus.o_error),      32'd0);
      check({tag, "_word_count"}, 32'(bus.o_word_count), 32'd0);
   endtask

   // A byte strobed during reset must be discarded.
   task automatic do_reset(input string tag);
      rst            = 1'b1;
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = 8'h4C;
      @(posedge clk);
      #1;
      check_outputs_zero(tag);
      bus.i_rx_valid = 1'b0;
      rst            = 1'b0;
      model_reset();
   endtask

   task automatic end_scenario(input string tag);
      idle(4);
      check({tag, "_pending"},    32'(exp_addr.size()),  32'd0);
      check({tag, "_busy"},       32'(bus.o_busy),       32'(m_mode == M_LOAD));
      check({tag, "_cpu_enable"}, 32'(bus.o_cpu_enable), 32'(m_mode == M_DONE));
      check({tag, "_error"},      32'(bus.o_error),      32'(m_mode == M_ERR));
      check({tag, "_word_count"}, 32'(bus.o_word_count), 32'(m_count));
   endtask

   function automatic logic [31:0] rand_nonhalt();
      return {8'($urandom_range(0, 254)), 24'($urandom)};
   endfunction

   function automatic logic [7:0] rand_byte();
      int r;
      r = $urandom_range(0, 15);
      if (r == 0) return 8'h4C;
      if (r == 1) return 8'h52;
      if (r <= 3) return 8'hFF;
      return 8'($urandom);
   endfunction

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   initial begin
      rst            = 1'b1;
      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = 8'h00;
      model_reset();

      // Directed load with latency check, ending on the halt word.
      do_reset("rst0");
      drive_byte(8'h4C);
      drive_byte(8'h00);
      drive_byte(8'h01);
      drive_byte(8'h10);
      drive_byte(8'h20);
      check("lat_write_cycle_wr_en", 32'(bus.o_wr_en), 32'd0);
      check("lat_write_cycle_busy",  32'(bus.o_busy),  32'd1);
      idle(1);
      check("lat_pulse_wr_en", 32'(bus.o_wr_en), 32'd1);
      check("lat_pulse_count", 32'(bus.o_word_count), 32'd1);
      idle(1);
      check("lat_pulse_one_cycle", 32'(bus.o_wr_en), 32'd0);
      drive_byte(8'hFF);
      drive_byte(8'hFF);
      drive_byte(8'hFF);
      check("halt_cpu_still_off", 32'(bus.o_cpu_enable), 32'd0);
      drive_byte(8'hFF);
      idle(1);
      check("halt_write_pulse", 32'(bus.o_wr_en), 32'd1);
      idle(1);
      check("halt_cpu_on", 32'(bus.o_cpu_enable), 32'd1);
      end_scenario("directed");

      // Run command from idle; a later load command is ignored.
      do_reset("rst1");
      drive_byte(8'h52);
      check("run_cpu_next_cycle", 32'(bus.o_cpu_enable), 32'd1);
      check("run_no_busy",        32'(bus.o_busy),       32'd0);
      drive_byte(8'h4C);
      for (int i = 0; i < 8; i++) drive_byte(8'($urandom));
      end_scenario("run");

      // Overflow: 15 words fit, the 16th (addr 60) does not.
      do_reset("rst2");
      drive_byte(8'h4C);
      for (int i = 0; i < 16; i++) send_word(rand_nonhalt(), 2);
      for (int i = 0; i < 4; i++) drive_byte(8'($urandom));
      end_scenario("overflow");
      check("overflow_count_15", 32'(bus.o_word_count), 32'd15);
      check("overflow_error",    32'(bus.o_error),      32'd1);

      // Back-to-back bytes: next word's first byte lands in the WRITE cycle.
      do_reset("rst3");
      drive_byte(8'h4C);
      for (int i = 0; i < 3; i++) send_word(rand_nonhalt(), 0);
      send_word(32'hFFFF_FFFF, 0);
      end_scenario("b2b");
      check("b2b_count_4", 32'(bus.o_word_count), 32'd4);

      // Reset in the middle of a word after one completed write.
      do_reset("rst4");
      drive_byte(8'h4C);
      send_word(32'h1234_5678, 1);
      drive_byte(8'hAA);
      drive_byte(8'hBB);
      idle(2);
      do_reset("rst_mid");
      drive_byte(8'h4C);
      send_word(rand_nonhalt(), 1);
      end_scenario("after_reset");
      check("after_reset_count_1", 32'(bus.o_word_count), 32'd1);

      // Junk before the load; command values inside data.
      do_reset("rst5");
      drive_byte(8'h00);
      drive_byte(8'h4C);
      send_word(32'h4C4C_4C4C, 0);
      end_scenario("cmd_as_data");

      // Random byte streams.
      for (int round = 0; round < 8; round++) begin
         int n;
         do_reset("rst_rand");
         if ($urandom_range(0, 3) != 0) drive_byte(8'h4C);
         n = $urandom_range(0, 72);
         for (int i = 0; i < n; i++) begin
            drive_byte(rand_byte());
            idle($urandom_range(0, 2));
         end
         end_scenario("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
